prio_rr_arb: RTL and testbench
==============================

// Module: prio_rr_arb
// PURPOSE
//  Round-robin arbiter sharing one resource among N = 2**CODE_WIDTH requesters.
//  Issues a registered one-hot grant plus a binary grant code and holds it until release.
//  Grant code has the width produced by the team's priority encoders.
//  Sits in front of shared utils datapaths such as bus masters or a shared FIFO port.
// PARAMETERS
//  CODE_WIDTH  2   grant code width; requester count N = 2**CODE_WIDTH (CODE_WIDTH >= 1)
//  MAX_HOLD    16  max grant cycles before forced release (used only with timeout feature; >= 2)
// PORTS
//  clk          in   1           single clock; all logic rising-edge
//  rst_n        in   1           asynchronous, active-low reset
//  req          in   N           request per requester, level, held until served
//  done         in   1           release pulse from the current grant holder
//  grant        out  N           one-hot grant, registered; all-zero when idle
//  grant_valid  out  1           high while any grant is held (== |grant)
//  grant_code   out  CODE_WIDTH  binary index of the holder; 0 when grant_valid=0
//  timeout      out  1           1-cycle pulse on forced release; constant 0 without PRIO_RR_ARB_TIMEOUT_EN
// BEHAVIOUR
//  Reset (async, rst_n=0): grant=0, grant_valid=0, grant_code=0, timeout=0, state=IDLE,
//   ptr=N-1, so the first search starts at index 0. Applies mid-grant: grant drops immediately.
//  FSM: IDLE, BUSY.
//  Arbitration: search starts at index ptr+1 mod N and wraps. The first set req bit wins.
//   Implemented as masked = req & ~((2<<ptr)-1). Pick the lowest index of masked, else the lowest of req.
//  IDLE: if |req, register the winner next edge; goto BUSY; ptr <= winner.
//   Latency is 1 cycle from req sampled to grant.
//  BUSY: grant held stable. Release occurs on done=1, or on req[grant_code]=0 (holder withdrew).
//   On release, arbitration runs in the same cycle over req with the holder's bit masked out.
//   If any other req is set, the new grant is registered at the next edge (back-to-back, zero idle cycles).
//   Otherwise grant=0 and the FSM goes to IDLE.
//  Holder re-request: after release, the holder's bit is ignored for that one arbitration.
//   It competes normally from the next arbitration onward.
//  done in IDLE is ignored. done and a new req in the same cycle are both honoured.
//  req bits may change at any time. Only bits sampled at the arbitration edge matter.
//  grant is always one-hot or zero. grant_code always equals the index of the set grant bit.
// CONFIGURATION
//  `PRIO_RR_ARB_TIMEOUT_EN defined:
//   - 8-bit-min counter hold_cnt clears on each new grant and increments every cycle in BUSY.
//   - If hold_cnt == MAX_HOLD-1 and there is no release, the grant is forcibly released.
//     Re-arbitration then follows the normal release rules, and timeout pulses 1 cycle with the new grant edge.
//   - A forced release with no other requester returns to IDLE. The holder may win again on the following arbitration.
//  `PRIO_RR_ARB_TIMEOUT_EN undefined: no counter, MAX_HOLD unused, timeout tied 0.
//   The grant is held indefinitely until release.
// STRUCTURE
//  Package prio_rr_arb_pkg: state_t enum {IDLE, BUSY}.
//   Also holds the function onehot(code) and the constant HOLD_CNT_W = max(8, $clog2(MAX_HOLD)).
//  Sub-module rr_mask_sel (combinational): inputs req, ptr, excl.
//   Outputs any and win_code, the lowest-index pick over the masked set, then over the full set.
//   The FSM plus registers live in prio_rr_arb.
// TESTING  (CODE_WIDTH=2, MAX_HOLD=4)
//  1 Reset, then req=4'b1010 -> next edge grant=4'b0010, code=1. Pulse done -> next edge grant=4'b1000, code=3.
//  2 Holding 3 with req=4'b1011, done -> grant=4'b0001 (wrap). Done again -> grant=4'b0010. Done with req=0 -> grant=0, IDLE.
//  3 Single requester req=4'b0100, done each grant -> alternates grant=4'b0100 and 0 (holder excluded 1 arb), never other bits.
//  4 Holder drops req[2] without done while req=4'b0001 pending -> next edge grant=4'b0001.
//  5 rst_n low mid-BUSY -> grant, grant_valid, grant_code go 0 without a clock edge. Release -> first grant starts search at 0.
//  6 TIMEOUT_EN: req=4'b0011 held, no done -> grant 0001 for 4 cycles, then grant=4'b0010 with timeout=1 for one cycle.
//    Without the macro: grant 0001 held for 20+ cycles and timeout stays 0.

Source files
------------

// File: rtl/prio_rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Holds the FSM state type, the one-hot decoder and the hold-counter width rule.
package prio_rr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned MAX_CODE_W = 8;
    localparam int unsigned ONEHOT_W   = 2 ** MAX_CODE_W;

    function automatic logic [ONEHOT_W-1:0] onehot(input logic [MAX_CODE_W-1:0] code);
        logic [ONEHOT_W-1:0] vec;
        vec       = '0;
        vec[code] = 1'b1;
        return vec;
    endfunction

    // Counter is at least 8 bits wide so small MAX_HOLD values share one layout.
    function automatic int unsigned hold_cnt_width(input int unsigned max_hold);
        int unsigned w;
        w = $clog2(max_hold);
        return (w > 8) ? w : 8;
    endfunction

endpackage

// File: rtl/prio_rr_arb_mask_sel.sv
// Round-robin winner select: lowest eligible index above ptr, else lowest eligible overall.
// Bits set in excl are removed from the eligible set before searching.
module rr_mask_sel #(
    parameter int unsigned CODE_WIDTH = 2
) (
    input  logic [2**CODE_WIDTH-1:0] req,
    input  logic [CODE_WIDTH-1:0]    ptr,
    input  logic [2**CODE_WIDTH-1:0] excl,
    output logic                     any,
    output logic [CODE_WIDTH-1:0]    win_code
);
    localparam int unsigned N = 2 ** CODE_WIDTH;

    logic [N-1:0] eligible;
    logic [N-1:0] upper;
    logic         found;

    always_comb begin
        eligible = req & ~excl;
        upper    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            upper[i] = eligible[i] && (CODE_WIDTH'(i) > ptr);
        end

        any      = |eligible;
        win_code = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (upper[i] && !found) begin
                win_code = CODE_WIDTH'(i);
                found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (eligible[i] && !found) begin
                win_code = CODE_WIDTH'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_rr_arb.sv
// Round-robin arbiter with registered one-hot grant held until release.
// Optional forced release after MAX_HOLD cycles: define PRIO_RR_ARB_TIMEOUT_EN.
module prio_rr_arb
    import prio_rr_arb_pkg::*;
#(
    parameter int unsigned CODE_WIDTH = 2,
    parameter int unsigned MAX_HOLD   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2**CODE_WIDTH-1:0] req,
    input  logic                     done,
    output logic [2**CODE_WIDTH-1:0] grant,
    output logic                     grant_valid,
    output logic [CODE_WIDTH-1:0]    grant_code,
    output logic                     timeout
);
    localparam int unsigned N          = 2 ** CODE_WIDTH;
    localparam int unsigned HOLD_CNT_W = hold_cnt_width(MAX_HOLD);

    state_t                state;
    logic [CODE_WIDTH-1:0] ptr;
    logic                  any;
    logic [CODE_WIDTH-1:0] win_code;
    logic [ONEHOT_W-1:0]   win_full;
    logic [N-1:0]          win_onehot;
    logic                  released;
    logic                  forced;
    logic                  rearb;

    // Outside BUSY grant is zero, so excluding grant only affects a releasing holder.
    rr_mask_sel #(
        .CODE_WIDTH(CODE_WIDTH)
    ) u_sel (
        .req      (req),
        .ptr      (ptr),
        .excl     (grant),
        .any      (any),
        .win_code (win_code)
    );

    always_comb begin
        win_full   = onehot(MAX_CODE_W'(win_code));
        win_onehot = win_full[N-1:0];
    end

`ifdef PRIO_RR_ARB_TIMEOUT_EN
    logic [HOLD_CNT_W-1:0] hold_cnt;

    always_comb begin
        released = (state == BUSY) && (done || !req[grant_code]);
        forced   = (state == BUSY) && !released && (hold_cnt == HOLD_CNT_W'(MAX_HOLD - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= forced;
            if (rearb && any) begin
                hold_cnt <= '0;
            end else if (state == BUSY) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_max_hold;

    assign unused_max_hold = 32'(MAX_HOLD + HOLD_CNT_W);
    assign timeout         = 1'b0;

    always_comb begin
        released = (state == BUSY) && (done || !req[grant_code]);
        forced   = 1'b0;
    end
`endif

    assign rearb       = (state == IDLE) || released || forced;
    assign grant_valid = |grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            grant_code <= '0;
            ptr        <= '1;
        end else if (rearb) begin
            if (any) begin
                state      <= BUSY;
                grant      <= win_onehot;
                grant_code <= win_code;
                ptr        <= win_code;
            end else begin
                state      <= IDLE;
                grant      <= '0;
                grant_code <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_rr_arb.sv
// Self-checking bench for prio_rr_arb (CODE_WIDTH=2, MAX_HOLD=4): vector table,
// hand sequences for reset/timeout corners, and random traffic against a queue-free reference model.
module tb_prio_rr_arb;
    localparam int CW       = 2;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
`ifdef PRIO_RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [CW-1:0] grant_code;
    logic          timeout;

    int tests  = 0;
    int failed = 0;

    // reference model state: holder index (-1 idle), last winner, cycles held
    int m_holder;
    int m_ptr;
    int m_cnt;
    bit m_to;

    prio_rr_arb #(
        .CODE_WIDTH(CW),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_code  (grant_code),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  r;
        logic          d;
        logic [N-1:0]  g;
        logic [CW-1:0] c;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [N-1:0] r, input int from, input int skip);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (from + k) % N;
            if (r[idx] && idx != skip) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_holder = -1;
        m_ptr    = N - 1;
        m_cnt    = 0;
        m_to     = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic d);
        int w;
        bit rel;
        bit frc;
        m_to = 1'b0;
        if (m_holder < 0) begin
            w = search(r, m_ptr, -1);
            if (w >= 0) begin
                m_holder = w;
                m_ptr    = w;
                m_cnt    = 0;
            end
        end else begin
            rel = d || !r[m_holder];
            frc = TO_EN && !rel && (m_cnt == MAX_HOLD - 1);
            if (rel || frc) begin
                w = search(r, m_ptr, m_holder);
                m_to = frc;
                if (w >= 0) begin
                    m_holder = w;
                    m_ptr    = w;
                    m_cnt    = 0;
                end else begin
                    m_holder = -1;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Drive inputs mid-cycle, advance the model, then sample 1 time unit after the edge.
    task automatic step(input logic [N-1:0] r, input logic d);
        req  = r;
        done = d;
        model_edge(r, d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_model(input string tag);
        logic [N-1:0]  eg;
        logic [CW-1:0] ec;
        eg = '0;
        ec = '0;
        if (m_holder >= 0) begin
            eg[m_holder] = 1'b1;
            ec = CW'(m_holder);
        end
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".code"}, 32'(grant_code), 32'(ec));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(m_holder >= 0));
        chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{4'b1010, 1'b0, 4'b0010, 2'd1};
        vecs[1]  = '{4'b1010, 1'b1, 4'b1000, 2'd3};
        vecs[2]  = '{4'b1011, 1'b1, 4'b0001, 2'd0};
        vecs[3]  = '{4'b1011, 1'b1, 4'b0010, 2'd1};
        vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 2'd0};
        vecs[5]  = '{4'b0100, 1'b0, 4'b0100, 2'd2};
        vecs[6]  = '{4'b0100, 1'b1, 4'b0000, 2'd0};
        vecs[7]  = '{4'b0100, 1'b0, 4'b0100, 2'd2};
        vecs[8]  = '{4'b0100, 1'b1, 4'b0000, 2'd0};
        vecs[9]  = '{4'b0100, 1'b0, 4'b0100, 2'd2};
        vecs[10] = '{4'b0101, 1'b0, 4'b0100, 2'd2};
        vecs[11] = '{4'b0001, 1'b0, 4'b0001, 2'd0};
        vecs[12] = '{4'b0000, 1'b0, 4'b0000, 2'd0};
        vecs[13] = '{4'b0000, 1'b1, 4'b0000, 2'd0};
        vecs[14] = '{4'b0010, 1'b1, 4'b0010, 2'd1};

        do_reset();
        chk("reset.grant", 32'(grant), 32'h0);
        chk("reset.valid", 32'(grant_valid), 32'h0);
        chk("reset.code", 32'(grant_code), 32'h0);
        chk("reset.timeout", 32'(timeout), 32'h0);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].r, vecs[i].d);
            chk($sformatf("vec%0d.grant", i), 32'(grant), 32'(vecs[i].g));
            chk($sformatf("vec%0d.code", i), 32'(grant_code), 32'(vecs[i].c));
            chk($sformatf("vec%0d.valid", i), 32'(grant_valid), 32'(vecs[i].g != 0));
            chk($sformatf("vec%0d.timeout", i), 32'(timeout), 32'h0);
        end

        // asynchronous reset while a grant is held
        do_reset();
        step(4'b0110, 1'b0);
        chk("async.pre_grant", 32'(grant), 32'h2);
        step(4'b0110, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async.grant", 32'(grant), 32'h0);
        chk("async.valid", 32'(grant_valid), 32'h0);
        chk("async.code", 32'(grant_code), 32'h0);
        #2;
        rst_n = 1'b1;
        step(4'b1111, 1'b0);
        chk("async.first_grant", 32'(grant), 32'h1);
        chk("async.first_code", 32'(grant_code), 32'h0);

        // long hold: forced release with the timeout feature, indefinite hold without it
        do_reset();
        step(4'b0011, 1'b0);
        chk("hold.first", 32'(grant), 32'h1);
        if (TO_EN) begin
            for (int i = 0; i < 3; i++) begin
                step(4'b0011, 1'b0);
                chk($sformatf("hold.keep%0d", i), 32'(grant), 32'h1);
                chk($sformatf("hold.to%0d", i), 32'(timeout), 32'h0);
            end
            step(4'b0011, 1'b0);
            chk("hold.forced_grant", 32'(grant), 32'h2);
            chk("hold.forced_timeout", 32'(timeout), 32'h1);
            step(4'b0011, 1'b0);
            chk("hold.after_grant", 32'(grant), 32'h2);
            chk("hold.after_timeout", 32'(timeout), 32'h0);
        end else begin
            for (int i = 0; i < 20; i++) begin
                step(4'b0011, 1'b0);
                chk($sformatf("hold.keep%0d", i), 32'(grant), 32'h1);
                chk($sformatf("hold.to%0d", i), 32'(timeout), 32'h0);
            end
        end

        // random traffic against the reference model
        do_reset();
        begin
            logic [N-1:0] r;
            r = '0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 2) == 0) r = N'($urandom_range(0, 15));
                step(r, $urandom_range(0, 3) == 0);
                chk_model($sformatf("rand%0d", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
